reg_bank_scheduler: RTL and testbench

- Shares one bank of DEPTH signed 10-bit working registers between NREQ datapath requesters, e.g. transform, clip and raster stages holding vertex coordinates.
- Requesters are arbitrated round-robin, with one bank access per cycle: read, write or saturating accumulate.
- A sequenced bank clear runs one entry per cycle and stalls all requesters while it runs.
- Sits between the pipeline stages and the shared register storage.

---
 rtl/reg_bank_scheduler_pkg.sv | 10 +
 rtl/reg_bank_scheduler_rr_arbiter.sv | 23 ++
 rtl/reg_bank_scheduler.sv | 81 ++++++++
 tb/tb_reg_bank_scheduler.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/reg_bank_scheduler_pkg.sv
// reg_bank_scheduler_pkg: op/state encodings and data limits shared by the bank scheduler
package reg_bank_scheduler_pkg;
  localparam int DEF_WIDTH = 10;
  localparam int DATA_MAX = 2 ** (DEF_WIDTH - 1) - 1;
  localparam int DATA_MIN = -(2 ** (DEF_WIDTH - 1));
  localparam logic [1:0] OP_RD = 2'b00;
  localparam logic [1:0] OP_WR = 2'b01;
  localparam logic [1:0] OP_ACC = 2'b10;
  typedef enum logic {S_IDLE, S_CLEAR} state_e;
endpackage

// File: rtl/reg_bank_scheduler_rr_arbiter.sv
// rr_arbiter: combinational round-robin grant, searching upward from ptr with wrap
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int PW = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   ptr,
  output logic [NREQ-1:0] gnt,
  output logic [PW-1:0]   idx,
  output logic            any
);
  logic [NREQ-1:0] rot;
  int off, pos;
  always_comb begin
    rot = NREQ'({req, req} >> ptr);
    any = |req;
    off = 0;
    for (int k = NREQ - 1; k >= 0; k--) off = rot[k] ? k : off;
    pos = int'(ptr) + off;
    idx = PW'(pos >= NREQ ? pos - NREQ : pos);
    gnt = any ? NREQ'(1) << idx : '0;
  end
endmodule

// File: rtl/reg_bank_scheduler.sv
// reg_bank_scheduler: round-robin shared register bank with read/write/saturating
// accumulate, one access per cycle, and a sequenced one-entry-per-cycle clear.
module reg_bank_scheduler
  import reg_bank_scheduler_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = 8,
  parameter int AW = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [2*NREQ-1:0]     req_op,
  input  logic [AW*NREQ-1:0]    req_addr,
  input  logic [WIDTH*NREQ-1:0] req_wdata,
  output logic [NREQ-1:0]       req_ready,
  output logic [NREQ-1:0]       rsp_valid,
  output logic [WIDTH-1:0]      rsp_rdata,
  input  logic                  clr_req,
  output logic                  clr_done,
  output logic                  busy
);
  localparam int PW = $clog2(NREQ);
  localparam logic [WIDTH-1:0] MAXV = {1'b0, {(WIDTH - 1){1'b1}}};
  localparam logic [WIDTH-1:0] MINV = {1'b1, {(WIDTH - 1){1'b0}}};
  state_e state_q, state_d;
  logic [PW-1:0] rr_q, gidx;
  logic [AW-1:0] cnt_q, addr;
  logic [WIDTH-1:0] bank_q [DEPTH];
  logic [WIDTH-1:0] rdata_q, wdata, cur, acc;
  logic [WIDTH:0] sum;
  logic [NREQ-1:0] gnt, rsp_valid_q;
  logic [1:0] op;
  logic any, serve, xfer, is_rd, done_q;
  rr_arbiter #(.NREQ(NREQ)) u_arb (.req(req_valid), .ptr(rr_q), .gnt(gnt), .idx(gidx), .any(any));
  // A pending clear request outranks any requester in the same cycle.
  always_comb begin
    serve = rst_n && state_q == S_IDLE && !clr_req;
    xfer = serve && any;
    op = req_op[2*gidx +: 2];
    addr = req_addr[AW*gidx +: AW];
    wdata = req_wdata[WIDTH*gidx +: WIDTH];
    is_rd = op[1] == op[0];
    cur = bank_q[addr];
    sum = {cur[WIDTH-1], cur} + {wdata[WIDTH-1], wdata};
    acc = sum[WIDTH] ^ sum[WIDTH-1] ? (sum[WIDTH] ? MINV : MAXV) : sum[WIDTH-1:0];
    state_d = state_q == S_IDLE ? (clr_req ? S_CLEAR : S_IDLE)
                                : (cnt_q == AW'(DEPTH - 1) ? S_IDLE : S_CLEAR);
  end
  assign req_ready = serve ? gnt : '0;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rdata_q;
  assign clr_done = done_q;
  assign busy = state_q == S_CLEAR;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      rr_q <= '0;
      cnt_q <= '0;
      rsp_valid_q <= '0;
      rdata_q <= '0;
      done_q <= 1'b0;
      for (int i = 0; i < DEPTH; i++) bank_q[i] <= '0;
    end else begin
      state_q <= state_d;
      done_q <= state_q == S_CLEAR && cnt_q == AW'(DEPTH - 1);
      rsp_valid_q <= xfer && is_rd ? gnt : '0;
      if (xfer) begin
        rr_q <= gidx == PW'(NREQ - 1) ? '0 : gidx + 1'b1;
        if (is_rd) rdata_q <= cur;
        else bank_q[addr] <= op == OP_WR ? wdata : acc;
      end
      // cnt wraps back to 0 on its own because DEPTH is a power of two
      if (state_q == S_CLEAR) begin
        bank_q[cnt_q] <= '0;
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_reg_bank_scheduler.sv
// tb_reg_bank_scheduler: randomized + directed stimulus against a behavioural bank model,
// with read responses checked by an independent scoreboard monitor.
module tb_reg_bank_scheduler;
  import reg_bank_scheduler_pkg::*;
  localparam int NREQ = 4, WIDTH = 10, DEPTH = 8, AW = 3;
  logic clk = 1'b0, rst_n = 1'b0;
  logic [NREQ-1:0] req_valid, req_ready, rsp_valid;
  logic [2*NREQ-1:0] req_op;
  logic [AW*NREQ-1:0] req_addr;
  logic [WIDTH*NREQ-1:0] req_wdata;
  logic [WIDTH-1:0] rsp_rdata;
  logic clr_req, clr_done, busy;
  int tests = 0, fails = 0, cyc = 0;
  typedef struct {int r; int data; int due;} exp_t;
  exp_t q[$];
  int gq[$];
  int mbank[DEPTH];
  int mptr = 0, phase = -1;
  bit pv[NREQ], keep[NREQ];
  logic [1:0] po[NREQ];
  int pa[NREQ], pd[NREQ];
  bit clr_in = 1'b0;

  reg_bank_scheduler dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_op(req_op), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .clr_req(clr_req), .clr_done(clr_done), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string nm, logic signed [31:0] act, logic signed [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic int sat(int v);
    return v > 511 ? 511 : (v < -512 ? -512 : v);
  endfunction

  // One clock of stimulus: drive pending requests, check against the model, advance the model.
  task automatic cycle();
    int g;
    bit idle;
    @(negedge clk);
    for (int i = 0; i < NREQ; i++) begin
      req_valid[i] = pv[i];
      req_op[2*i +: 2] = po[i];
      req_addr[AW*i +: AW] = AW'(pa[i]);
      req_wdata[WIDTH*i +: WIDTH] = WIDTH'(pd[i]);
    end
    clr_req = clr_in;
    #1;
    idle = phase < 0 || phase == 9;
    chk("busy", busy, phase >= 1 && phase <= 8);
    chk("clr_done", clr_done, phase == 9);
    g = -1;
    if (idle && !clr_in)
      for (int k = NREQ - 1; k >= 0; k--) if (pv[(mptr + k) % NREQ]) g = (mptr + k) % NREQ;
    chk("req_ready", req_ready, g < 0 ? 0 : 1 << g);
    if (g >= 0) begin
      gq.push_back(g);
      mptr = (g + 1) % NREQ;
      if (po[g] == OP_WR) mbank[pa[g]] = pd[g];
      else if (po[g] == OP_ACC) mbank[pa[g]] = sat(mbank[pa[g]] + pd[g]);
      else q.push_back('{g, mbank[pa[g]], cyc + 1});
      if (!keep[g]) pv[g] = 1'b0;
    end
    if (idle && clr_in) begin
      phase = 1;
      foreach (mbank[i]) mbank[i] = 0;
    end else if (phase >= 1 && phase < 9) phase++;
    else phase = -1;
  endtask

  task automatic issue(int r, logic [1:0] op, int a, int d);
    pv[r] = 1'b1; po[r] = op; pa[r] = a; pd[r] = d;
    for (int n = 0; n < 50 && pv[r]; n++) cycle();
    if (pv[r]) begin
      chk("grant_timeout", pv[r], 0);
      pv[r] = 1'b0;
    end
  endtask

  // Scoreboard monitor: every response strobe must match the oldest expected read.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (!rst_n) continue;
      if (rsp_valid !== '0) begin
        if (q.size() == 0) chk("rsp_unexpected", rsp_valid, 0);
        else begin
          e = q.pop_front();
          chk("rsp_valid", rsp_valid, 1 << e.r);
          chk("rsp_rdata", $signed(rsp_rdata), e.data);
          chk("rsp_latency", cyc, e.due);
        end
      end else if (q.size() > 0 && q[0].due <= cyc) begin
        e = q.pop_front();
        chk("rsp_valid_missing", rsp_valid, 1 << e.r);
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int n, busy_n, done_n;
    int rr1[8] = '{0, 1, 2, 3, 0, 1, 2, 3};
    int rr2[4] = '{0, 2, 3, 0};
    foreach (pv[i]) begin pv[i] = 0; keep[i] = 0; po[i] = OP_RD; pa[i] = 0; pd[i] = 0; end
    foreach (mbank[i]) mbank[i] = 0;
    req_valid = '1; req_op = '0; req_addr = '0; req_wdata = '0; clr_req = 1'b0;
    #1;
    chk("reset_ready", req_ready, 0);
    chk("reset_rsp_valid", rsp_valid, 0);
    chk("reset_rdata", rsp_rdata, 0);
    chk("reset_clr_done", clr_done, 0);
    chk("reset_busy", busy, 0);
    repeat (2) @(negedge clk);
    req_valid = '0;
    rst_n = 1'b1;
    // write then read
    issue(0, OP_WR, 2, 37);
    issue(0, OP_RD, 2, 0);
    issue(3, OP_RD, 0, 0);
    // fairness with all requesters continuously valid
    foreach (pv[i]) begin pv[i] = 1; keep[i] = 1; po[i] = OP_RD; pa[i] = i; end
    gq.delete();
    repeat (8) cycle();
    chk("rr_count", gq.size(), 8);
    for (int i = 0; i < 8 && i < gq.size(); i++) chk("rr_order_all", gq[i], rr1[i]);
    keep[1] = 0; pv[1] = 0;
    gq.delete();
    repeat (4) cycle();
    chk("rr_count_drop", gq.size(), 4);
    for (int i = 0; i < 4 && i < gq.size(); i++) chk("rr_order_drop1", gq[i], rr2[i]);
    foreach (pv[i]) begin pv[i] = 0; keep[i] = 0; end
    // saturation
    issue(0, OP_WR, 5, 500);  issue(0, OP_ACC, 5, 20);   issue(0, OP_RD, 5, 0);
    issue(1, OP_WR, 5, -500); issue(1, OP_ACC, 5, -30);  issue(1, OP_RD, 5, 0);
    issue(2, OP_WR, 5, 100);  issue(2, OP_ACC, 5, -150); issue(2, OP_RD, 5, 0);
    // back-to-back write/read and reserved op
    issue(1, OP_WR, 7, -1);
    issue(1, OP_RD, 7, 0);
    issue(1, 2'b11, 7, 5);
    issue(2, OP_RD, 7, 0);
    // clear sequencing
    for (int i = 0; i < DEPTH; i++) issue(i % NREQ, OP_WR, i, (i + 1) * ((i % 2) ? -37 : 37));
    pv[2] = 1; po[2] = OP_RD; pa[2] = 3;
    clr_in = 1;
    n = 0; busy_n = 0; done_n = 0;
    for (int k = 0; k < 20 && pv[2]; k++) begin
      cycle();
      clr_in = 0;
      n += (req_ready == '0);
      busy_n += busy;
      done_n += clr_done;
    end
    chk("clr_stall_cycles", n, 9);
    chk("clr_busy_cycles", busy_n, 8);
    chk("clr_done_pulses", done_n, 1);
    for (int a = 0; a < DEPTH; a++) issue(a % NREQ, OP_RD, a, 0);
    // randomized traffic with occasional clears
    for (int k = 0; k < 300; k++) begin
      for (int i = 0; i < NREQ; i++)
        if (!pv[i] && $urandom_range(1) == 1) begin
          pv[i] = 1;
          po[i] = 2'($urandom_range(3));
          pa[i] = int'($urandom_range(DEPTH - 1));
          pd[i] = int'($urandom_range(1023)) - 512;
        end
      clr_in = $urandom_range(39) == 0;
      cycle();
    end
    clr_in = 0;
    for (int k = 0; k < 60 && (phase >= 0 || pv[0] || pv[1] || pv[2] || pv[3]); k++) cycle();
    chk("idle_after_random", phase, -1);
    // asynchronous reset in the middle of a clear
    clr_in = 1;
    cycle();
    clr_in = 0;
    repeat (4) cycle();
    @(negedge clk);
    #2;
    req_valid = '1;
    rst_n = 1'b0;
    #1;
    chk("midclr_rst_ready", req_ready, 0);
    chk("midclr_rst_rsp_valid", rsp_valid, 0);
    chk("midclr_rst_rdata", rsp_rdata, 0);
    chk("midclr_rst_clr_done", clr_done, 0);
    chk("midclr_rst_busy", busy, 0);
    foreach (mbank[i]) mbank[i] = 0;
    mptr = 0; phase = -1;
    q.delete();
    repeat (3) begin
      @(negedge clk);
      chk("rst_hold_clr_done", clr_done, 0);
    end
    req_valid = '0;
    rst_n = 1'b1;
    foreach (pv[i]) begin pv[i] = 1; po[i] = OP_RD; pa[i] = i + 4; end
    gq.delete();
    cycle();
    chk("post_rst_first_grant", gq.size() > 0 ? gq[0] : -1, 0);
    for (int k = 0; k < 10 && (pv[1] || pv[2] || pv[3]); k++) cycle();
    for (int a = 0; a < DEPTH; a++) issue(a % NREQ, OP_RD, a, 0);
    repeat (3) cycle();
    chk("rsp_drain", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
